// File: rtl/add_unit_scheduler.sv
// add_unit_scheduler: round-robin scheduler feeding one shared external 32-bit
// adder. It is a two-stage pipeline: S1 holds the granted operands that drive
// the adder, and S2 registers the adder's result. The result leaves on a
// valid/ready port.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   req_valid/req_ready        per-requester handshake; req_ready is one-hot
//   req_a/req_b/req_op/req_tag packed per-requester operands, op and tag
//   add_a/add_b/add_cin        drive the external adder (zero when S1 is empty)
//   add_sum/add_cout           results from the external adder
//   res_*                      registered result port toward the CDB arbiter
module add_unit_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [32*NREQ-1:0]     req_a,
  input  logic [32*NREQ-1:0]     req_b,
  input  logic [NREQ-1:0]        req_op,
  input  logic [TAGW*NREQ-1:0]   req_tag,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic [1:0]             add_cin,
  input  logic [31:0]            add_sum,
  input  logic [1:0]             add_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [TAGW-1:0]        res_tag,
  output logic                   res_carry,
  output logic                   res_ovf
);

  localparam int unsigned DW   = 32;
  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW   = PTRW + 1;

  logic            v1_q, v1_d;
  logic [DW-1:0]   a1_q, a1_d, b1_q, b1_d;
  logic [1:0]      cin1_q, cin1_d;
  logic [TAGW-1:0] tag1_q, tag1_d;
  logic            rv_q, rv_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [TAGW-1:0] rtag_q, rtag_d;
  logic            rcarry_q, rcarry_d;
  logic            rovf_q, rovf_d;
  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;

  logic [DW-1:0]   a_arr [NREQ];
  logic [DW-1:0]   b_arr [NREQ];
  logic [TAGW-1:0] t_arr [NREQ];

  logic            s2_free, s1_adv, s1_free, accept;
  logic            gnt_found;
  logic [PTRW-1:0] gnt_idx;
  logic [SW-1:0]   cand_w;
  logic [SW-1:0]   nxt_w;
  logic            unused_cout_hi;

  // Only the carry bit of the kill/generate code carries information.
  assign unused_cout_hi = add_cout[1];

  // Unpack the per-requester buses into arrays.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = req_a[DW*i +: DW];
      b_arr[i] = req_b[DW*i +: DW];
      t_arr[i] = req_tag[TAGW*i +: TAGW];
    end
  end

  assign s2_free = !rv_q | res_ready;
  assign s1_adv  = v1_q & s2_free;
  assign s1_free = !v1_q | s1_adv;

  // Round-robin search starting at rr_ptr and wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_w    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_w = {1'b0, rr_ptr_q} + SW'(k);
      if (cand_w >= SW'(NREQ)) cand_w = cand_w - SW'(NREQ);
      if (!gnt_found && req_valid[cand_w[PTRW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_w[PTRW-1:0];
      end
    end
  end

  assign accept    = gnt_found & s1_free & !reset;
  assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

  assign add_a   = v1_q ? a1_q : '0;
  assign add_b   = v1_q ? b1_q : '0;
  assign add_cin = v1_q ? cin1_q : 2'b00;

  assign res_valid = rv_q;
  assign res_data  = rdata_q;
  assign res_tag   = rtag_q;
  assign res_carry = rcarry_q;
  assign res_ovf   = rovf_q;

  // Next state for both pipeline stages and the round-robin pointer.
  always_comb begin
    v1_d     = v1_q;
    a1_d     = a1_q;
    b1_d     = b1_q;
    cin1_d   = cin1_q;
    tag1_d   = tag1_q;
    rv_d     = rv_q;
    rdata_d  = rdata_q;
    rtag_d   = rtag_q;
    rcarry_d = rcarry_q;
    rovf_d   = rovf_q;
    rr_ptr_d = rr_ptr_q;
    nxt_w    = '0;

    if (accept) begin
      v1_d   = 1'b1;
      a1_d   = a_arr[gnt_idx];
      b1_d   = req_op[gnt_idx] ? ~b_arr[gnt_idx] : b_arr[gnt_idx];
      cin1_d = req_op[gnt_idx] ? 2'b11 : 2'b00;
      tag1_d = t_arr[gnt_idx];
      nxt_w  = {1'b0, gnt_idx} + SW'(1);
      if (nxt_w == SW'(NREQ)) nxt_w = '0;
      rr_ptr_d = nxt_w[PTRW-1:0];
    end else if (s1_adv) begin
      v1_d = 1'b0;
    end

    if (s1_adv) begin
      rv_d     = 1'b1;
      rdata_d  = add_sum;
      rtag_d   = tag1_q;
      rcarry_d = add_cout[0];
      // Overflow: operand signs agree but the sum's sign differs.
      rovf_d   = (a1_q[DW-1] == b1_q[DW-1]) & (add_sum[DW-1] != a1_q[DW-1]);
    end else if (res_ready) begin
      rv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      cin1_q   <= 2'b00;
      tag1_q   <= '0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      rtag_q   <= '0;
      rcarry_q <= 1'b0;
      rovf_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      cin1_q   <= cin1_d;
      tag1_q   <= tag1_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
      rtag_q   <= rtag_d;
      rcarry_q <= rcarry_d;
      rovf_q   <= rovf_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
